// File: rtl/accum_arb_pkg.sv
// Shared types and constants for the accumulator round-robin arbiter.
//   state_e  : controller FSM states
//   pkt_t    : one 3-byte packet, byte0 in the low bits
//   pkt_byte : selects byte N of a packet
package accum_arb_pkg;

  localparam int PKT_BYTES = 3;
  localparam int BYTE_W    = 8;
  localparam int PKT_W     = PKT_BYTES * BYTE_W;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    WAIT,
    RESP
  } state_e;

  typedef struct packed {
    logic [BYTE_W-1:0] b2;
    logic [BYTE_W-1:0] b1;
    logic [BYTE_W-1:0] b0;
  } pkt_t;

  function automatic logic [BYTE_W-1:0] pkt_byte(input pkt_t p, input logic [1:0] sel);
    case (sel)
      2'd1:    return p.b1;
      2'd2:    return p.b2;
      default: return p.b0;
    endcase
  endfunction

endpackage

// File: rtl/accum_arbiter_rr_pick.sv
// Combinational round-robin priority picker.
//   req : request vector
//   ptr : index searched first; the search wraps from N-1 back to 0
//   gnt : one-hot winner (zero when no request)
//   idx : winner index
//   any : at least one request pending
module rr_pick #(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  // One extra bit so ptr+i can be folded back below N without overflow.
  logic [IDX_W:0] cand;
  logic           found;

  // NOTE: every output of a combinational block gets a default before any
  // branch; a path that leaves one unassigned infers a latch.
  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    for (int i = 0; i < N; i++) begin
      cand = {1'b0, ptr} + (IDX_W+1)'(i);
      if (cand >= (IDX_W+1)'(N)) cand = cand - (IDX_W+1)'(N);
      if (!found && req[cand[IDX_W-1:0]]) begin
        found                 = 1'b1;
        gnt[cand[IDX_W-1:0]] = 1'b1;
        idx                   = cand[IDX_W-1:0];
      end
    end
    any = found;
  end

endmodule

// File: rtl/accum_arbiter.sv
// Round-robin controller sharing one 3-byte Accumulator among N_REQ
// requesters. A granted packet is streamed byte0..byte2 on three consecutive
// acc_put cycles; the Accumulator's {r2,r1,r0} is returned to the winner on a
// valid/ready port with its id and an error flag (returned bytes differ from
// the packet sent, or timeout).
//
// Optional build macro ACCUM_ARB_TIMEOUT_EN: WAIT aborts after TIMEOUT cycles
// without acc_done, responding with rsp_data=0 and rsp_err=1. Without it WAIT
// waits indefinitely.
//
// Ports:
//   clk, reset (async, active low)
//   req[N_REQ], req_pkt[N_REQ*24] : per-requester pending level and packet
//   gnt[N_REQ]                    : one-cycle one-hot pulse when a packet is latched
//   acc_put, acc_value            : Accumulator putFlag / value
//   acc_r0..2, acc_r*_valid, acc_done : Accumulator results
//   rsp_valid/rsp_ready/rsp_id/rsp_data/rsp_err : response port
module accum_arbiter
  import accum_arb_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int ID_W  = $clog2(N_REQ)
`ifdef ACCUM_ARB_TIMEOUT_EN
  , parameter int TIMEOUT = 15
`endif
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*PKT_W-1:0] req_pkt,
  output logic [N_REQ-1:0]       gnt,
  output logic                   acc_put,
  output logic [BYTE_W-1:0]      acc_value,
  input  logic [BYTE_W-1:0]      acc_r0,
  input  logic [BYTE_W-1:0]      acc_r1,
  input  logic [BYTE_W-1:0]      acc_r2,
  input  logic                   acc_r0_valid,
  input  logic                   acc_r1_valid,
  input  logic                   acc_r2_valid,
  input  logic                   acc_done,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [ID_W-1:0]        rsp_id,
  output logic [PKT_W-1:0]       rsp_data,
  output logic                   rsp_err
);

  state_e            state_q, state_d;
  logic [1:0]        cnt_q, cnt_d;
  pkt_t              pkt_q, pkt_d;
  logic [ID_W-1:0]   id_q, id_d;
  logic [ID_W-1:0]   ptr_q, ptr_d;
  logic [PKT_W-1:0]  rsp_data_q, rsp_data_d;
  logic              rsp_err_q, rsp_err_d;

  logic [N_REQ-1:0]  pick_gnt;
  logic [ID_W-1:0]   pick_idx;
  logic              pick_any;
  logic [PKT_W-1:0]  ret_data;

  rr_pick #(.N(N_REQ), .IDX_W(ID_W)) u_pick (
    .req (req),
    .ptr (ptr_q),
    .gnt (pick_gnt),
    .idx (pick_idx),
    .any (pick_any)
  );

  assign ret_data = {acc_r2, acc_r1, acc_r0};

`ifdef ACCUM_ARB_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT + 1);
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             tmo_hit;

  // Counter only runs in WAIT, so it is already zero on every WAIT entry.
  always_comb begin
    tmo_d   = (state_q == WAIT) ? tmo_q + 1'b1 : '0;
    tmo_hit = (state_q == WAIT) && (tmo_q == TMO_W'(TIMEOUT - 1));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) tmo_q <= '0;
    else        tmo_q <= tmo_d;
  end
`endif

  // Outputs are decoded from state so that an asynchronous reset drops
  // acc_put and gnt in the same instant it clears the state register.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    pkt_d      = pkt_q;
    id_d       = id_q;
    ptr_d      = ptr_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;
    gnt        = '0;
    acc_put    = 1'b0;
    acc_value  = '0;
    rsp_valid  = 1'b0;

    case (state_q)
      IDLE: begin
        if (pick_any) begin
          gnt     = pick_gnt;
          pkt_d   = pkt_t'(req_pkt[PKT_W*int'(pick_idx) +: PKT_W]);
          id_d    = pick_idx;
          ptr_d   = (pick_idx == ID_W'(N_REQ - 1)) ? '0 : pick_idx + 1'b1;
          cnt_d   = '0;
          state_d = LOAD;
        end
      end
      LOAD: begin
        // The Accumulator discards partial bursts: put stays high all 3 cycles.
        acc_put   = 1'b1;
        acc_value = pkt_byte(pkt_q, cnt_q);
        if (cnt_q == 2'(PKT_BYTES - 1)) state_d = WAIT;
        else                            cnt_d   = cnt_q + 1'b1;
      end
      WAIT: begin
        if (acc_done && acc_r0_valid && acc_r1_valid && acc_r2_valid) begin
          rsp_data_d = ret_data;
          rsp_err_d  = (ret_data != pkt_q);
          state_d    = RESP;
        end
`ifdef ACCUM_ARB_TIMEOUT_EN
        else if (tmo_hit) begin
          rsp_data_d = '0;
          rsp_err_d  = 1'b1;
          state_d    = RESP;
        end
`endif
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state flops use non-blocking assignments so every register samples
  // the values from before the edge, independent of block ordering.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      pkt_q      <= '0;
      id_q       <= '0;
      ptr_q      <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pkt_q      <= pkt_d;
      id_q       <= id_d;
      ptr_q      <= ptr_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
    end
  end

  assign rsp_id   = id_q;
  assign rsp_data = rsp_data_q;
  assign rsp_err  = rsp_err_q;

endmodule

// File: tb/tb_accum_arbiter.sv
// Scoreboard bench for accum_arbiter: directed stimulus pushes expected grants,
// bytes and responses into queues; a monitor pops and compares them whenever
// the DUT shows gnt, acc_put or an accepted response. A behavioural
// Accumulator returns the collected bytes one cycle after the third put.
module tb_accum_arbiter;

  localparam int N_REQ   = 4;
  localparam int ID_W    = 2;
  localparam int TIMEOUT = 15;

  typedef struct packed {
    logic [ID_W-1:0] id;
    logic [23:0]     data;
    logic            err;
  } rsp_t;

  logic               clk = 1'b0;
  logic               reset = 1'b0;
  logic [N_REQ-1:0]   req = '0;
  logic [N_REQ*24-1:0] req_pkt = '0;
  logic [N_REQ-1:0]   gnt;
  logic               acc_put;
  logic [7:0]         acc_value;
  logic [7:0]         acc_r0, acc_r1, acc_r2;
  logic               acc_r0_valid, acc_r1_valid, acc_r2_valid;
  logic               acc_done;
  logic               rsp_valid;
  logic               rsp_ready = 1'b1;
  logic [ID_W-1:0]    rsp_id;
  logic [23:0]        rsp_data;
  logic               rsp_err;

  int n_cmp = 0;
  int n_err = 0;
  bit in_flight = 1'b0;
  bit corrupt = 1'b0;
  bit no_done = 1'b0;

  logic [N_REQ-1:0] exp_gnt[$];
  logic [7:0]       exp_byte[$];
  rsp_t             exp_rsp[$];

  always #5 clk = ~clk;

  accum_arbiter #(.N_REQ(N_REQ), .ID_W(ID_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .req          (req),
    .req_pkt      (req_pkt),
    .gnt          (gnt),
    .acc_put      (acc_put),
    .acc_value    (acc_value),
    .acc_r0       (acc_r0),
    .acc_r1       (acc_r1),
    .acc_r2       (acc_r2),
    .acc_r0_valid (acc_r0_valid),
    .acc_r1_valid (acc_r1_valid),
    .acc_r2_valid (acc_r2_valid),
    .acc_done     (acc_done),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_id       (rsp_id),
    .rsp_data     (rsp_data),
    .rsp_err      (rsp_err)
  );

  // Accumulator model: collects three put bytes, pulses done next cycle.
  logic [1:0] m_cnt;
  logic [7:0] m_b0, m_b1;
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_cnt <= '0; m_b0 <= '0; m_b1 <= '0;
      acc_done <= 1'b0; acc_r0 <= '0; acc_r1 <= '0; acc_r2 <= '0;
      acc_r0_valid <= 1'b0; acc_r1_valid <= 1'b0; acc_r2_valid <= 1'b0;
    end else begin
      acc_done <= 1'b0;
      acc_r0_valid <= 1'b0; acc_r1_valid <= 1'b0; acc_r2_valid <= 1'b0;
      if (acc_put) begin
        if (m_cnt == 2'd0) m_b0 <= acc_value;
        if (m_cnt == 2'd1) m_b1 <= acc_value;
        if (m_cnt == 2'd2) begin
          m_cnt <= '0;
          if (!no_done) begin
            acc_done <= 1'b1;
            acc_r0 <= m_b0;
            acc_r1 <= corrupt ? (m_b1 ^ 8'h01) : m_b1;
            acc_r2 <= acc_value;
            acc_r0_valid <= 1'b1; acc_r1_valid <= 1'b1; acc_r2_valid <= 1'b1;
          end
        end else begin
          m_cnt <= m_cnt + 2'd1;
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_evt(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s: unexpected event at %0t", name, $time);
  endtask

  // Monitor: samples 2ns after the falling edge, when inputs are settled.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (gnt != '0) begin
        if (in_flight) fail_evt("gnt_while_busy");
        in_flight = 1'b1;
        if (exp_gnt.size() == 0) fail_evt("gnt_unexpected");
        else check("gnt_order", 32'(gnt), 32'(exp_gnt.pop_front()));
      end
      if (acc_put) begin
        if (exp_byte.size() == 0) fail_evt("put_unexpected");
        else check("acc_value", 32'(acc_value), 32'(exp_byte.pop_front()));
      end
      if (rsp_valid && rsp_ready) begin
        in_flight = 1'b0;
        if (exp_rsp.size() == 0) fail_evt("rsp_unexpected");
        else begin
          rsp_t e;
          e = exp_rsp.pop_front();
          check("rsp_id",   32'(rsp_id),   32'(e.id));
          check("rsp_data", 32'(rsp_data), 32'(e.data));
          check("rsp_err",  32'(rsp_err),  32'(e.err));
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic set_pkt(input int i, input logic [23:0] p);
    req_pkt[24*i +: 24] = p;
  endtask

  task automatic push_txn(input int id, input logic [23:0] pkt, input logic [23:0] ret,
                          input logic err, input bit with_rsp, input int nbytes);
    rsp_t r;
    exp_gnt.push_back(N_REQ'(1) << id);
    for (int b = 0; b < nbytes; b++) exp_byte.push_back(pkt[8*b +: 8]);
    if (with_rsp) begin
      r.id = ID_W'(id); r.data = ret; r.err = err;
      exp_rsp.push_back(r);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_gnt"},       32'(gnt),       32'h0);
    check({tag, "_acc_put"},   32'(acc_put),   32'h0);
    check({tag, "_acc_value"}, 32'(acc_value), 32'h0);
    check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'h0);
    check({tag, "_rsp_id"},    32'(rsp_id),    32'h0);
    check({tag, "_rsp_data"},  32'(rsp_data),  32'h0);
    check({tag, "_rsp_err"},   32'(rsp_err),   32'h0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    req = '0;
    in_flight = 1'b0;
    @(negedge clk);
    #1;
    check_reset_outputs("reset");
    reset = 1'b1;
  endtask

  // Present req for exactly one IDLE cycle.
  task automatic one_shot(input logic [N_REQ-1:0] mask);
    @(negedge clk);
    req = mask;
    @(negedge clk);
    req = '0;
  endtask

  task automatic drain(input string tag, input int budget);
    int k = 0;
    while (exp_rsp.size() != 0 && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (exp_rsp.size() != 0) begin
      fail_evt({tag, "_drain_timeout"});
      exp_rsp.delete(); exp_gnt.delete(); exp_byte.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    int k;
    int seen;

    do_reset();

    // Single requester 1; also measure gnt -> rsp_valid latency.
    push_txn(1, 24'h3C2814, 24'h3C2814, 1'b0, 1'b1, 3);
    @(negedge clk);
    set_pkt(1, 24'h3C2814);
    req = 4'b0010;
    @(negedge clk);
    req = '0;
    k = 1;
    while (!rsp_valid && k < 30) begin
      @(negedge clk);
      k++;
    end
    check("t1_latency", 32'(k), 32'd5);
    drain("t1", 30);

    // Round robin with all requests held: 0,1,2,3,0.
    do_reset();
    set_pkt(0, 24'h030201); set_pkt(1, 24'h131211);
    set_pkt(2, 24'h232221); set_pkt(3, 24'h333231);
    push_txn(0, 24'h030201, 24'h030201, 1'b0, 1'b1, 3);
    push_txn(1, 24'h131211, 24'h131211, 1'b0, 1'b1, 3);
    push_txn(2, 24'h232221, 24'h232221, 1'b0, 1'b1, 3);
    push_txn(3, 24'h333231, 24'h333231, 1'b0, 1'b1, 3);
    push_txn(0, 24'h030201, 24'h030201, 1'b0, 1'b1, 3);
    @(negedge clk);
    req = 4'b1111;
    seen = 0;
    k = 0;
    while (seen < 5 && k < 200) begin
      @(negedge clk);
      k++;
      if (rsp_valid) begin
        seen++;
        if (seen == 5) req = '0;
      end
    end
    req = '0;
    check("t2_rsp_count", 32'(seen), 32'd5);
    drain("t2", 30);

    // Accumulator corrupts r1: error flagged, returned bytes reported.
    corrupt = 1'b1;
    set_pkt(2, 24'h3C2814);
    push_txn(2, 24'h3C2814, 24'h3C2914, 1'b1, 1'b1, 3);
    one_shot(4'b0100);
    drain("t3", 30);
    corrupt = 1'b0;

    // Back-pressure: 10 cycles with rsp_ready low while requester 0 waits.
    rsp_ready = 1'b0;
    set_pkt(3, 24'hA5B6C7);
    push_txn(3, 24'hA5B6C7, 24'hA5B6C7, 1'b0, 1'b1, 3);
    one_shot(4'b1000);
    k = 0;
    while (!rsp_valid && k < 30) begin
      @(negedge clk);
      k++;
    end
    set_pkt(0, 24'h0D0E0F);
    req = 4'b0001;
    push_txn(0, 24'h0D0E0F, 24'h0D0E0F, 1'b0, 1'b1, 3);
    for (int i = 0; i < 10; i++) begin
      #1;
      check("t4_hold_valid", 32'(rsp_valid), 32'h1);
      check("t4_hold_id",    32'(rsp_id),    32'h3);
      check("t4_hold_data",  32'(rsp_data),  32'hA5B6C7);
      check("t4_hold_err",   32'(rsp_err),   32'h0);
      check("t4_no_gnt",     32'(gnt),       32'h0);
      check("t4_no_put",     32'(acc_put),   32'h0);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    #1;
    check("t4_idle_after_accept", 32'(gnt), 32'b0001);
    @(negedge clk);
    req = '0;
    drain("t4", 30);

    // Reset during the second LOAD cycle.
    set_pkt(1, 24'h665544);
    push_txn(1, 24'h665544, 24'h0, 1'b0, 1'b0, 1);
    one_shot(4'b0010);
    @(negedge clk);
    #1;
    check("t5_put_before_rst", 32'(acc_put),   32'h1);
    check("t5_byte1",          32'(acc_value), 32'h55);
    reset = 1'b0;
    in_flight = 1'b0;
    #1;
    check_reset_outputs("t5_rst");
    @(negedge clk);
    reset = 1'b1;
    // ptr back at 0 picks 1 from 0110 (a stale ptr of 2 would pick 2).
    set_pkt(1, 24'h778899); set_pkt(2, 24'hC0FFEE);
    push_txn(1, 24'h778899, 24'h778899, 1'b0, 1'b1, 3);
    one_shot(4'b0110);
    drain("t5a", 30);
    push_txn(2, 24'hC0FFEE, 24'hC0FFEE, 1'b0, 1'b1, 3);
    one_shot(4'b0100);
    drain("t5b", 30);

    // Accumulator never reports done.
    no_done = 1'b1;
    set_pkt(0, 24'h0A0B0C);
`ifdef ACCUM_ARB_TIMEOUT_EN
    push_txn(0, 24'h0A0B0C, 24'h0, 1'b1, 1'b1, 3);
    @(negedge clk);
    req = 4'b0001;
    @(negedge clk);
    req = '0;
    k = 1;
    while (!rsp_valid && k < 80) begin
      @(negedge clk);
      k++;
    end
    // WAIT is entered 4 cycles after the grant.
    check("t6_timeout_latency", 32'(k), 32'(4 + TIMEOUT));
    drain("t6", 30);
    no_done = 1'b0;
`else
    push_txn(0, 24'h0A0B0C, 24'h0, 1'b0, 1'b0, 3);
    one_shot(4'b0001);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (rsp_valid) seen++;
    end
    check("t6_no_rsp_without_done", 32'(seen), 32'h0);
    no_done = 1'b0;
    do_reset();
`endif

    @(negedge clk);
    check("end_gnt_queue",  32'(exp_gnt.size()),  32'h0);
    check("end_byte_queue", 32'(exp_byte.size()), 32'h0);
    check("end_rsp_queue",  32'(exp_rsp.size()),  32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
